// File: rtl/rv_mem_pkg.sv
// Shared types and helpers for the data-memory responder.
// funct3 encodings, FSM states and access legality checks.
package rv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } dmem_state_t;

  function automatic logic is_misaligned(
    input logic [2:0] funct3,
    input logic [1:0] addr
  );
    logic r;
    case (funct3[1:0])
      2'b01:   r = addr[0];
      2'b10:   r = (addr != 2'b00);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_illegal(
    input logic       we,
    input logic [2:0] funct3
  );
    logic r;
    if (we)
      r = !(funct3 inside {F3_B, F3_H, F3_W});
    else
      r = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    return r;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: load extraction/extension and store merge.
// Purely combinational; the caller decides when results are used.
module dmem_lane_align
  import rv_mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] rdata_o,
  output logic [31:0] merged_o
);

  logic [31:0] shifted;
  logic [4:0]  bsh;
  logic [4:0]  hsh;

  assign bsh     = {off_i, 3'b000};
  assign hsh     = {off_i[1], 4'b0000};
  assign shifted = word_i >> bsh;

  always_comb begin
    rdata_o = '0;
    case (funct3_i)
      F3_B:    rdata_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   rdata_o = {24'h0, shifted[7:0]};
      F3_H:    rdata_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   rdata_o = {16'h0, shifted[15:0]};
      F3_W:    rdata_o = word_i;
      default: rdata_o = '0;
    endcase
  end

  always_comb begin
    merged_o = word_i;
    case (funct3_i[1:0])
      2'b00:   merged_o[bsh +: 8]  = wdata_i[7:0];
      2'b01:   merged_o[hsh +: 16] = wdata_i[15:0];
      2'b10:   merged_o            = wdata_i;
      default: merged_o            = word_i;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM behind a valid/ready request and
// response pair, with programmable wait states and RV32I lane handling.
module dmem_responder
  import rv_mem_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int LATENCY       = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [2:0]               req_funct3,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic                     resp_err
);

  localparam int DEPTH = 2 ** (ADDRESS_WIDTH - 2);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY > 0 ? LATENCY - 1 : 0);

  dmem_state_t state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic [DATA_WIDTH-1:0] resp_rdata_q;
  logic        resp_err_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic        idle;
  logic        cur_we;
  logic [2:0]  cur_f3;
  logic [ADDRESS_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0]    cur_wdata;
  logic [ADDRESS_WIDTH-3:0] idx;
  logic        acc_err;
  logic        enter_resp;
  logic        cur_err;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [DATA_WIDTH-1:0] st_word;

  // A zero-latency or errored request commits on its accept edge,
  // so the datapath reads the live request while idle.
  assign idle      = (state_q == IDLE);
  assign cur_we    = idle ? req_we     : we_q;
  assign cur_f3    = idle ? req_funct3 : f3_q;
  assign cur_addr  = idle ? req_addr   : addr_q;
  assign cur_wdata = idle ? req_wdata  : wdata_q;
  assign idx       = cur_addr[ADDRESS_WIDTH-1:2];

  assign acc_err = is_illegal(req_we, req_funct3)
                 | is_misaligned(req_funct3, req_addr[1:0]);
  assign cur_err = idle & acc_err;

  assign enter_resp =
      (idle && req_valid && (acc_err || LATENCY == 0))
    || (state_q == BUSY && cnt_q == 4'd0);

  dmem_lane_align u_align (
    .word_i   (mem[idx]),
    .wdata_i  (cur_wdata),
    .off_i    (cur_addr[1:0]),
    .funct3_i (cur_f3),
    .rdata_o  (ld_data),
    .merged_o (st_word)
  );

  always_ff @(posedge clk) begin
    if (enter_resp && !rst && cur_we && !cur_err)
      mem[idx] <= st_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      f3_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q        <= req_we;
            f3_q        <= req_funct3;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            req_ready_q <= 1'b0;
            if (acc_err || LATENCY == 0) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= acc_err;
              resp_rdata_q <= (acc_err || req_we) ? '0 : ld_data;
            end else begin
              state_q <= BUSY;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        BUSY: begin
          if (cnt_q == 4'd0) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= we_q ? '0 : ld_data;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder that services load/store requests from the single-cycle RV32I core's load/store path. It is the target end of the core's data-memory request/response interface. It sits beside the core top, holds a word-organised RAM, and returns load data with a programmable wait-state latency. It supports RV32I byte, half and word accesses with sign or zero extension, and flags misaligned or illegal accesses.

Parameters:
ADDRESS_WIDTH, 8, byte-address width; RAM depth is 2**(ADDRESS_WIDTH-2) 32-bit words
DATA_WIDTH, 32, data width; fixed at 32 for RV32I
LATENCY, 2, wait-state cycles between request accept and response; legal range 0..15

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I funct3: LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010
req_addr  input  ADDRESS_WIDTH  byte address
req_wdata  input  DATA_WIDTH  store data, right-aligned
resp_valid  output  1  response present
resp_ready  input  1  requester accepts response
resp_rdata  output  DATA_WIDTH  extended load data; 0 for stores and errors
resp_err  output  1  misaligned or illegal access

Behaviour:
- Reset (async, active-high): state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0. RAM contents are not reset.
- FSM states: IDLE, BUSY, RESP.
- IDLE: req_ready=1. On req_valid & req_ready at edge E0, latch we, funct3, addr and wdata, then evaluate err:
  - err=1 when funct3 is not in the legal set for the direction (loads: 011, 110, 111; stores: anything other than 000/001/010).
  - err=1 for a halfword access with addr[0]=1.
  - err=1 for a word access with addr[1:0]≠0.
- Next state from IDLE: if err or LATENCY=0, go to RESP. Otherwise go to BUSY with counter=LATENCY-1.
- BUSY: req_ready=0. If counter=0, go to RESP; otherwise decrement.
- Response timing: resp_valid becomes visible after edge E0+LATENCY for legal accesses, and after E0+0 for errors.
- Commit point is the edge that enters RESP:
  - Stores write only the addressed byte lanes: SB writes 1 lane, SH writes 2 lanes, SW writes all 4.
  - Loads register resp_rdata from the RAM word. LB/LH sign-extend; LBU/LHU zero-extend.
  - An errored access never writes; it returns resp_rdata=0 and resp_err=1.
- RESP: resp_valid=1. resp_rdata and resp_err stay stable until resp_valid & resp_ready, then the FSM returns to IDLE. This gives one bubble cycle: back-to-back throughput is one request per LATENCY+2 cycles.
- req_ready=0 in BUSY and RESP. req_valid may be high in those states and is simply not accepted.
- Reset mid-operation returns to IDLE immediately. A store still in BUSY is abandoned with no RAM write. A store that has reached RESP has already committed.
- Address wrap: the word index is addr[ADDRESS_WIDTH-1:2], so out-of-range access is impossible by construction.
- A load following a store to the same address returns the stored data, because the store commits before its response is seen.

Decomposition:
- Package rv_mem_pkg holds:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU
  - state enum dmem_state_t {IDLE, BUSY, RESP}
  - function is_misaligned(funct3, addr[1:0])
- One combinational sub-module, dmem_lane_align:
  - Load side: (word, addr[1:0], funct3) → extended rdata.
  - Store side: (old word, wdata, addr[1:0], funct3) → merged word.
  - The FSM, counter and RAM stay in dmem_responder.

Test Plan:
- Reset: assert rst mid-cycle → outputs immediately req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
- SW 0xDEADBEEF @0x10, then LW @0x10, LATENCY=2:
  - resp_valid rises 2 edges after each accept edge.
  - Load returns 0xDEADBEEF with resp_err=0.
  - req_ready=0 throughout BUSY/RESP.
- SB 0x000000AB @0x05 over a word of zeros, then:
  - LB @0x05 → 0xFFFFFFAB
  - LBU @0x05 → 0x000000AB
  - LW @0x04 → 0x0000AB00
- LW @0x02 and SH @0x03 → resp_err=1 after 1 edge with resp_rdata=0; a following LW @0x00 shows the word unchanged.
- Back-pressure: hold resp_ready=0 for 3 cycles during an LH of 0x8001 → resp_valid, resp_rdata=0xFFFF8001 and resp_err stay stable; release → IDLE next edge.
- Reset during BUSY of SW 0x12345678 @0x20 (LATENCY=3) → LW @0x20 afterwards returns the prior value. LATENCY=0 build: response after 1 edge.
